// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_CH channels.
// A granted channel streams len+1 beats straight through before priority rotates.
module fifo_wr_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_WD = 4,
    parameter int LEN_WD  = 4,
    localparam int ID_WD  = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic [NUM_CH*LEN_WD-1:0]    ch_len,
    input  logic [NUM_CH*DATA_WD-1:0]   ch_data,
    input  logic [NUM_CH-1:0]           ch_valid,
    output logic [NUM_CH-1:0]           ch_ready,
    output logic [NUM_CH-1:0]           ch_done,
    output logic [DATA_WD-1:0]          fifo_data,
    output logic                        fifo_valid,
    input  logic                        fifo_ready,
    output logic [ID_WD-1:0]            grant_id,
    output logic                        busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [ID_WD-1:0]    grant_nxt;
    logic [ID_WD-1:0]    last, last_nxt;
    logic [LEN_WD-1:0]   cnt, cnt_nxt;
    logic [ID_WD-1:0]    winner;
    logic                found;
    logic                fire;
    int                  idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            cnt      <= '0;
            last     <= ID_WD'(NUM_CH - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
        end
    end

    // First requester after the most recently served channel wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last) + k) % NUM_CH;
            if (!found && ch_req[idx]) begin
                found  = 1'b1;
                winner = ID_WD'(idx);
            end
        end
    end

    assign busy      = (state == BURST);
    assign fifo_data = ch_data[int'(grant_id)*DATA_WD +: DATA_WD];

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        cnt_nxt    = cnt;
        last_nxt   = last;
        fifo_valid = 1'b0;
        ch_ready   = '0;
        ch_done    = '0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BURST;
                    grant_nxt = winner;
                    cnt_nxt   = ch_len[int'(winner)*LEN_WD +: LEN_WD];
                end
            end
            BURST: begin
                fifo_valid         = ch_valid[grant_id];
                ch_ready[grant_id] = fifo_ready;
                fire               = fifo_valid && fifo_ready;
                if (fire) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        // A burst cut short by reset never reports completion.
                        ch_done[grant_id] = !rst;
                        state_nxt         = IDLE;
                        last_nxt          = grant_id;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for single-channel and
// round-robin traffic, hand sequences for backpressure, stalls, max length, reset.
module tb_fifo_wr_arbiter;

    localparam int NUM_CH  = 4;
    localparam int DATA_WD = 4;
    localparam int LEN_WD  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_req;
    logic [15:0] ch_len;
    logic [15:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_done;
    logic [3:0]  fifo_data;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(.NUM_CH(NUM_CH), .DATA_WD(DATA_WD), .LEN_WD(LEN_WD)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_len(ch_len), .ch_data(ch_data),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_done(ch_done),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  valid;
        logic        fr;
        logic        e_fv;
        logic [3:0]  e_data;
        logic [3:0]  e_rdy;
        logic [3:0]  e_done;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    vec_t tbl [21];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [15:0] ln,
                                input logic [3:0] vl, input logic f, input logic fv,
                                input logic [3:0] d, input logic [3:0] rdy,
                                input logic [3:0] dn, input logic [1:0] g, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.len = ln; v.valid = vl; v.fr = f;
        v.e_fv = fv; v.e_data = d; v.e_rdy = rdy; v.e_done = dn; v.e_gid = g; v.e_busy = b;
        return v;
    endfunction

    int beats, done_beat, done_cnt;
    logic [3:0] done_val;

    initial begin
        rst = 1'b1; ch_req = '0; ch_len = '0; ch_valid = '0; fifo_ready = 1'b1;
        ch_data = 16'hDCBA;

        // single channel 1, len 3
        tbl[0]  = mk(0, 4'b0000, 16'h0000, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[1]  = mk(0, 4'b0010, 16'h0030, 4'b0010, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[2]  = mk(0, 4'b0010, 16'h0030, 4'b0010, 1, 1, 4'hB, 4'b0010, 4'b0000, 2'd1, 1);
        tbl[3]  = mk(0, 4'b0010, 16'h0030, 4'b0010, 1, 1, 4'hB, 4'b0010, 4'b0000, 2'd1, 1);
        tbl[4]  = mk(0, 4'b0010, 16'h0030, 4'b0010, 1, 1, 4'hB, 4'b0010, 4'b0000, 2'd1, 1);
        tbl[5]  = mk(0, 4'b0010, 16'h0030, 4'b0010, 1, 1, 4'hB, 4'b0010, 4'b0010, 2'd1, 1);
        tbl[6]  = mk(0, 4'b0000, 16'h0000, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd1, 0);
        // reset, then round robin with all channels requesting len 0
        tbl[7]  = mk(1, 4'b0000, 16'h0000, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd1, 0);
        tbl[8]  = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[9]  = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 1, 4'hA, 4'b0001, 4'b0001, 2'd0, 1);
        tbl[10] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[11] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 1, 4'hB, 4'b0010, 4'b0010, 2'd1, 1);
        tbl[12] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd1, 0);
        tbl[13] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 1, 4'hC, 4'b0100, 4'b0100, 2'd2, 1);
        tbl[14] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd2, 0);
        tbl[15] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 1, 4'hD, 4'b1000, 4'b1000, 2'd3, 1);
        tbl[16] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd3, 0);
        tbl[17] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 1, 4'hA, 4'b0001, 4'b0001, 2'd0, 1);
        tbl[18] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd0, 0);
        tbl[19] = mk(0, 4'b1111, 16'h0000, 4'b1111, 1, 1, 4'hB, 4'b0010, 4'b0010, 2'd1, 1);
        tbl[20] = mk(0, 4'b0000, 16'h0000, 4'b0000, 1, 0, 4'h0, 4'b0000, 4'b0000, 2'd1, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; ch_req = tbl[i].req; ch_len = tbl[i].len;
            ch_valid = tbl[i].valid; fifo_ready = tbl[i].fr;
            #4;
            chk($sformatf("row%0d fifo_valid", i), 32'(fifo_valid), 32'(tbl[i].e_fv));
            chk($sformatf("row%0d ch_ready", i), 32'(ch_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d ch_done", i), 32'(ch_done), 32'(tbl[i].e_done));
            chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].e_gid));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_busy)
                chk($sformatf("row%0d fifo_data", i), 32'(fifo_data), 32'(tbl[i].e_data));
            tick();
        end

        // FIFO backpressure: ch2 len 5, fifo_ready low for burst cycles 2..6
        rst = 1'b1; ch_req = '0; ch_valid = '0; fifo_ready = 1'b1;
        tick();
        rst = 1'b0; ch_req = 4'b0100; ch_len = 16'h0500; ch_valid = 4'b0100;
        tick();
        beats = 0; done_beat = 0; done_cnt = 0; done_val = '0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) ch_req = '0;
            fifo_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            #4;
            if (fifo_valid && fifo_ready) beats++;
            if (ch_done != '0) begin done_cnt++; done_val = ch_done; done_beat = beats; end
            if (c == 4) begin
                chk("bp stall fifo_valid", 32'(fifo_valid), 32'd1);
                chk("bp stall ch_ready", 32'(ch_ready), 32'd0);
                chk("bp stall fifo_data", 32'(fifo_data), 32'hC);
            end
            if (c == 12) chk("bp busy after", 32'(busy), 32'd0);
            tick();
        end
        chk("bp beats", 32'(beats), 32'd6);
        chk("bp done beat", 32'(done_beat), 32'd6);
        chk("bp done value", 32'(done_val), 32'b0100);
        chk("bp done count", 32'(done_cnt), 32'd1);

        // source stall and mid-burst length change: ch0 len 2
        fifo_ready = 1'b1; ch_req = 4'b0001; ch_len = 16'h0002; ch_valid = 4'b0001;
        tick();
        beats = 0; done_beat = 0; done_cnt = 0; done_val = '0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) ch_req = '0;
            if (c == 2) ch_len = 16'h0007;
            ch_valid = (c >= 2 && c <= 4) ? 4'b0000 : 4'b0001;
            #4;
            if (fifo_valid && fifo_ready) beats++;
            if (ch_done != '0) begin done_cnt++; done_val = ch_done; done_beat = beats; end
            if (c == 3) begin
                chk("stall fifo_valid", 32'(fifo_valid), 32'd0);
                chk("stall ch_ready", 32'(ch_ready), 32'b0001);
            end
            if (c == 7) chk("stall busy after", 32'(busy), 32'd0);
            tick();
        end
        chk("stall beats", 32'(beats), 32'd3);
        chk("stall done beat", 32'(done_beat), 32'd3);
        chk("stall done value", 32'(done_val), 32'b0001);
        chk("stall done count", 32'(done_cnt), 32'd1);

        // max length with request dropped after grant: ch3 len 15
        ch_req = 4'b1000; ch_len = 16'hF000; ch_valid = 4'b1000;
        tick();
        beats = 0; done_beat = 0; done_cnt = 0; done_val = '0;
        for (int c = 1; c <= 20; c++) begin
            ch_req = '0;
            #4;
            if (fifo_valid && fifo_ready) beats++;
            if (ch_done != '0) begin done_cnt++; done_val = ch_done; done_beat = beats; end
            if (c == 17) chk("max busy after", 32'(busy), 32'd0);
            tick();
        end
        chk("max beats", 32'(beats), 32'd16);
        chk("max done beat", 32'(done_beat), 32'd16);
        chk("max done value", 32'(done_val), 32'b1000);
        chk("max done count", 32'(done_cnt), 32'd1);

        // reset during beat 2 of a ch1 len 7 burst
        ch_req = 4'b0010; ch_len = 16'h0070; ch_valid = 4'b0010;
        tick();
        #4;
        chk("rstmid grant", 32'(grant_id), 32'd1);
        tick();
        rst = 1'b1;
        #4;
        chk("rstmid done during rst", 32'(ch_done), 32'd0);
        tick();
        rst = 1'b0; ch_req = 4'b0011; ch_valid = 4'b0011;
        #4;
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid fifo_valid", 32'(fifo_valid), 32'd0);
        chk("rstmid ch_ready", 32'(ch_ready), 32'd0);
        chk("rstmid ch_done", 32'(ch_done), 32'd0);
        tick();
        #4;
        chk("rstmid regrant id", 32'(grant_id), 32'd0);
        chk("rstmid regrant busy", 32'(busy), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
